multicore_launch_ctrl: RTL and testbench
========================================

MULTICORE_LAUNCH_CTRL -- requirements
Module: multicore_launch_ctrl

Interface
REQ-001 SHALL have parameter NumCores, default 4, number of vector cores controlled (legal 1..16).
REQ-002 SHALL have parameter StaggerWidth, default 8, width of the inter-launch gap counter.
REQ-003 SHALL have port clk_i, input, 1, system clock.
REQ-004 SHALL have port rst_ni, input, 1; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port reg_req_i, input, 1, register access request.
REQ-006 SHALL have port reg_we_i, input, 1, 1=write, 0=read.
REQ-007 SHALL have port reg_addr_i, input, 5, byte address.
REQ-008 SHALL have port reg_wdata_i, input, 32, write data.
REQ-009 SHALL have port reg_rdata_o, output, 32, read data.
REQ-010 SHALL have port reg_ack_o, output, 1, access completion.
REQ-011 SHALL have port core_rst_no, output, NumCores, per-core active-low reset.
REQ-012 SHALL have port core_fetch_en_o, output, NumCores, per-core fetch enable.
REQ-013 SHALL have port core_boot_addr_o, output, 32, shared boot address.
REQ-014 SHALL have port core_done_i, input, NumCores, per-core single-cycle done pulse.
REQ-015 SHALL have port irq_done_o, output, 1, level interrupt.

Function
REQ-016 Register map SHALL be: 0x00 CTRL (bit0 START, bit1 ABORT, both write-1 self-clearing; bit2 IRQ_EN, read/write); 0x04 MASK[NumCores-1:0]; 0x08 BOOT_ADDR; 0x0C STATUS (bit0 BUSY, bit1 DONE W1C, bit2 ABORTED W1C); 0x10 STAGGER[StaggerWidth-1:0]; 0x14 CYCLES (read-only); 0x18 PENDING (read-only).
REQ-017 reg_ack_o SHALL pulse exactly one cycle after each reg_req_i cycle; reg_rdata_o valid in the ack cycle, otherwise 0; unmapped addresses read 0, writes ignored, still acked.
REQ-018 Writes to MASK, BOOT_ADDR and STAGGER while BUSY SHALL be ignored; START while BUSY SHALL be ignored.
REQ-019 FSM states SHALL be IDLE, RELEASE, RUN, FINISH; BUSY=1 in every state except IDLE.
REQ-020 IDLE: all core_rst_no=0 and all core_fetch_en_o=0; START with MASK!=0 -> RELEASE with index=0, PENDING=MASK, CYCLES=0; START with MASK==0 -> sets DONE in the next cycle and stays in IDLE.
REQ-021 RELEASE: an index whose MASK bit is clear SHALL be skipped in one cycle; for a set bit, core_rst_no[i] and core_fetch_en_o[i] SHALL go to 1 in the next cycle and the FSM SHALL wait STAGGER further cycles before advancing; after index NumCores-1 -> RUN.
REQ-022 core_done_i[i] SHALL clear PENDING[i] only if core i is released; pulses from unreleased or unmasked cores SHALL be ignored, including in RELEASE.
REQ-023 RUN: PENDING==0 -> FINISH; FINISH lasts one cycle: all cores back to reset and fetch disabled, DONE=1, -> IDLE.
REQ-024 CYCLES SHALL increment every cycle BUSY=1, from 0 at START, saturating at 0xFFFFFFFF.
REQ-025 ABORT in RELEASE/RUN/FINISH SHALL, in the next cycle, enter IDLE, put all cores in reset, set ABORTED, leave DONE unchanged; ABORT in IDLE SHALL have no effect.
REQ-026 ABORT in the same cycle as the last done pulse SHALL win: ABORTED=1, DONE unchanged.
REQ-027 A DONE/ABORTED hardware set coinciding with its W1C write SHALL leave the bit set.
REQ-028 irq_done_o SHALL equal (DONE|ABORTED) & IRQ_EN, combinationally from registered state.
REQ-029 core_boot_addr_o SHALL drive BOOT_ADDR continuously.

Reset
REQ-030 With rst_ni=0 at a clk_i edge: FSM=IDLE; all registers, PENDING, CYCLES, index and stagger count =0; core_rst_no=0, core_fetch_en_o=0, core_boot_addr_o=0, reg_ack_o=0, reg_rdata_o=0, irq_done_o=0.
REQ-031 Reset mid-run SHALL discard the run without setting DONE or ABORTED.

Verification
REQ-032 NumCores=4, MASK=0b1011, STAGGER=2, START -> core 0 released at T+1, core 1 at T+4, core 3 at T+8, core 2 never; PENDING=0b1011.
REQ-033 Done pulses on cores 3,0,1 at separated cycles, IRQ_EN=1 -> FINISH one cycle after the last pulse, DONE=1, irq_done_o=1, all core_rst_no=0, CYCLES = BUSY cycle count.
REQ-034 Done pulse on core 2 (unmasked) and on core 3 before its release -> ignored; PENDING unchanged.
REQ-035 ABORT during RUN with PENDING=0b0010 -> next cycle IDLE, ABORTED=1, DONE=0, cores in reset; W1C of ABORTED clears irq_done_o.
REQ-036 START with MASK=0 -> DONE=1 after one cycle, no core released, CYCLES=0.
REQ-037 Write MASK=0xF while BUSY, then read MASK -> old value returned with ack one cycle after request; read of 0x1C -> 0.

Source files
------------

// File: rtl/multicore_launch_ctrl.sv
// Register-programmed launcher that releases a masked set of vector cores one by one
// with a programmable gap, then waits for every released core to report done.
module multicore_launch_ctrl #(
    parameter int NumCores     = 4,
    parameter int StaggerWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                reg_req_i,
    input  logic                reg_we_i,
    input  logic [4:0]          reg_addr_i,
    input  logic [31:0]         reg_wdata_i,
    output logic [31:0]         reg_rdata_o,
    output logic                reg_ack_o,
    output logic [NumCores-1:0] core_rst_no,
    output logic [NumCores-1:0] core_fetch_en_o,
    output logic [31:0]         core_boot_addr_o,
    input  logic [NumCores-1:0] core_done_i,
    output logic                irq_done_o
);

    localparam int IdxW = (NumCores > 1) ? $clog2(NumCores) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumCores - 1);

    typedef enum logic [1:0] {IDLE, RELEASE, RUN, FINISH} state_e;

    state_e                  state_q;
    logic [IdxW-1:0]         index_q;
    logic [StaggerWidth-1:0] staggerCnt_q;
    logic                    waiting_q;
    logic [NumCores-1:0]     mask_q;
    logic [31:0]             bootAddr_q;
    logic [StaggerWidth-1:0] stagger_q;
    logic                    irqEn_q;
    logic                    done_q;
    logic                    aborted_q;
    logic [NumCores-1:0]     pending_q;
    logic [NumCores-1:0]     pending_d;
    logic [31:0]             cycles_q;
    logic [31:0]             cycles_d;
    logic [NumCores-1:0]     released_q;
    logic                    ack_q;
    logic [31:0]             rdata_q;

    logic        wrEn, ctrlWr, maskWr, bootWr, statusWr, staggerWr;
    logic        startReq, abortReq, busy, relAdvance;
    logic [31:0] readData;

    assign wrEn      = reg_req_i & reg_we_i;
    assign ctrlWr    = wrEn && (reg_addr_i == 5'h00);
    assign maskWr    = wrEn && (reg_addr_i == 5'h04);
    assign bootWr    = wrEn && (reg_addr_i == 5'h08);
    assign statusWr  = wrEn && (reg_addr_i == 5'h0C);
    assign staggerWr = wrEn && (reg_addr_i == 5'h10);
    assign startReq  = ctrlWr & reg_wdata_i[0];
    assign abortReq  = ctrlWr & reg_wdata_i[1];
    assign busy      = (state_q != IDLE);

    // Done pulses only count for cores that are actually out of reset
    assign pending_d = pending_q & ~(core_done_i & released_q);
    assign cycles_d  = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;

    assign relAdvance = waiting_q ? (staggerCnt_q <= StaggerWidth'(1))
                                  : (!mask_q[index_q] || (stagger_q == '0));

    always_comb begin
        readData = '0;
        case (reg_addr_i)
            5'h00:   readData = {29'd0, irqEn_q, 2'b00};
            5'h04:   readData = 32'(mask_q);
            5'h08:   readData = bootAddr_q;
            5'h0C:   readData = {29'd0, aborted_q, done_q, busy};
            5'h10:   readData = 32'(stagger_q);
            5'h14:   readData = cycles_q;
            5'h18:   readData = 32'(pending_q);
            default: readData = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            index_q      <= '0;
            staggerCnt_q <= '0;
            waiting_q    <= 1'b0;
            mask_q       <= '0;
            bootAddr_q   <= '0;
            stagger_q    <= '0;
            irqEn_q      <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            pending_q    <= '0;
            cycles_q     <= '0;
            released_q   <= '0;
            ack_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            ack_q   <= reg_req_i;
            rdata_q <= (reg_req_i && !reg_we_i) ? readData : 32'd0;

            if (ctrlWr) irqEn_q <= reg_wdata_i[2];
            if (!busy && maskWr)    mask_q     <= reg_wdata_i[NumCores-1:0];
            if (!busy && bootWr)    bootAddr_q <= reg_wdata_i;
            if (!busy && staggerWr) stagger_q  <= reg_wdata_i[StaggerWidth-1:0];

            // Clears come first so a same-cycle hardware set below overrides them
            if (statusWr && reg_wdata_i[1]) done_q    <= 1'b0;
            if (statusWr && reg_wdata_i[2]) aborted_q <= 1'b0;

            pending_q <= pending_d;
            if (busy) cycles_q <= cycles_d;

            if (state_q == IDLE) begin
                if (startReq) begin
                    cycles_q <= '0;
                    if (mask_q != '0) begin
                        state_q      <= RELEASE;
                        index_q      <= '0;
                        waiting_q    <= 1'b0;
                        staggerCnt_q <= '0;
                        pending_q    <= mask_q;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
            end else if (abortReq) begin
                state_q      <= IDLE;
                released_q   <= '0;
                aborted_q    <= 1'b1;
                index_q      <= '0;
                waiting_q    <= 1'b0;
                staggerCnt_q <= '0;
            end else begin
                case (state_q)
                    RELEASE: begin
                        if (!waiting_q && mask_q[index_q]) released_q[index_q] <= 1'b1;
                        if (relAdvance) begin
                            waiting_q    <= 1'b0;
                            staggerCnt_q <= '0;
                            if (index_q == LastIdx) state_q <= RUN;
                            else                    index_q <= index_q + IdxW'(1);
                        end else if (waiting_q) begin
                            staggerCnt_q <= staggerCnt_q - StaggerWidth'(1);
                        end else begin
                            waiting_q    <= 1'b1;
                            staggerCnt_q <= stagger_q;
                        end
                    end
                    RUN: begin
                        if (pending_d == '0) begin
                            state_q    <= FINISH;
                            released_q <= '0;
                        end
                    end
                    FINISH: begin
                        state_q <= IDLE;
                        index_q <= '0;
                        done_q  <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign reg_ack_o        = ack_q;
    assign reg_rdata_o      = rdata_q;
    assign core_rst_no      = released_q;
    assign core_fetch_en_o  = released_q;
    assign core_boot_addr_o = bootAddr_q;
    assign irq_done_o       = (done_q | aborted_q) & irqEn_q;

endmodule

// File: tb/tb_multicore_launch_ctrl.sv
// Scoreboard bench for multicore_launch_ctrl: register reads are queued with their
// expected data and retired by an independent ack monitor.
module tb_multicore_launch_ctrl;

    localparam logic [4:0] ACtrl    = 5'h00;
    localparam logic [4:0] AMask    = 5'h04;
    localparam logic [4:0] ABoot    = 5'h08;
    localparam logic [4:0] AStatus  = 5'h0C;
    localparam logic [4:0] AStagger = 5'h10;
    localparam logic [4:0] ACycles  = 5'h14;
    localparam logic [4:0] APending = 5'h18;
    localparam logic [4:0] AUnmap   = 5'h1C;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        reg_req_i = 1'b0;
    logic        reg_we_i = 1'b0;
    logic [4:0]  reg_addr_i = '0;
    logic [31:0] reg_wdata_i = '0;
    logic [31:0] reg_rdata_o;
    logic        reg_ack_o;
    logic [3:0]  core_rst_no;
    logic [3:0]  core_fetch_en_o;
    logic [31:0] core_boot_addr_o;
    logic [3:0]  core_done_i = '0;
    logic        irq_done_o;

    multicore_launch_ctrl #(.NumCores(4), .StaggerWidth(8)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .reg_req_i       (reg_req_i),
        .reg_we_i        (reg_we_i),
        .reg_addr_i      (reg_addr_i),
        .reg_wdata_i     (reg_wdata_i),
        .reg_rdata_o     (reg_rdata_o),
        .reg_ack_o       (reg_ack_o),
        .core_rst_no     (core_rst_no),
        .core_fetch_en_o (core_fetch_en_o),
        .core_boot_addr_o(core_boot_addr_o),
        .core_done_i     (core_done_i),
        .irq_done_o      (irq_done_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          ackCyc;
        logic        isRead;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   failures = 0;
    int   relCyc[4] = '{-1, -1, -1, -1};
    logic [3:0] prevRst = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // One register access per call; entered and left just after a falling edge
    task automatic applyStimulus(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expData, input string name);
        exp_t e;
        reg_req_i   = 1'b1;
        reg_we_i    = we;
        reg_addr_i  = addr;
        reg_wdata_i = wdata;
        e.ackCyc = cyc + 1;
        e.isRead = !we;
        e.data   = expData;
        e.name   = name;
        sbQ.push_back(e);
        @(negedge clk_i);
        reg_req_i   = 1'b0;
        reg_we_i    = 1'b0;
        reg_addr_i  = '0;
        reg_wdata_i = '0;
    endtask

    task automatic regWrite(input logic [4:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, addr, data, 32'd0, "write");
    endtask

    task automatic regRead(input logic [4:0] addr, input logic [31:0] expData, input string name);
        applyStimulus(1'b0, addr, 32'd0, expData, name);
    endtask

    task automatic pulseDone(input logic [3:0] m);
        core_done_i = m;
        @(negedge clk_i);
        core_done_i = '0;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk_i);
    endtask

    // Monitor: retires scoreboard entries on every ack and tracks core release edges
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (reg_ack_o) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected ack: got ack=1, expected no ack (cycle %0d)", cyc);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput({e.name, " ack cycle"}, 32'(cyc), 32'(e.ackCyc));
                    if (e.isRead) checkOutput(e.name, reg_rdata_o, e.data);
                end
            end else begin
                checkOutput("rdata outside ack", reg_rdata_o, 32'd0);
            end
            for (int i = 0; i < 4; i++)
                if (core_rst_no[i] && !prevRst[i]) relCyc[i] = cyc;
            prevRst = core_rst_no;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        int p;

        repeat (3) @(negedge clk_i);
        checkOutput("reset core_rst_no", 32'(core_rst_no), 32'd0);
        checkOutput("reset fetch_en", 32'(core_fetch_en_o), 32'd0);
        checkOutput("reset boot_addr", core_boot_addr_o, 32'd0);
        checkOutput("reset ack", 32'(reg_ack_o), 32'd0);
        checkOutput("reset irq", 32'(irq_done_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        regRead(ACtrl, 32'd0, "reset CTRL");
        regRead(AMask, 32'd0, "reset MASK");
        regRead(AStatus, 32'd0, "reset STATUS");
        regRead(ACycles, 32'd0, "reset CYCLES");
        regRead(APending, 32'd0, "reset PENDING");

        $display("[TB] START with empty mask");
        regWrite(ACtrl, 32'h1);
        regRead(AStatus, 32'h2, "empty-mask STATUS");
        regRead(ACycles, 32'd0, "empty-mask CYCLES");
        checkOutput("empty-mask cores", 32'(core_rst_no), 32'd0);
        regWrite(AStatus, 32'h2);
        regRead(AStatus, 32'd0, "DONE W1C");

        $display("[TB] staggered launch, mask 1011, stagger 2");
        regWrite(AMask, 32'hB);
        regWrite(ABoot, 32'h8000_1000);
        regWrite(AStagger, 32'd2);
        regWrite(ACtrl, 32'h4);
        regRead(ACtrl, 32'h4, "CTRL IRQ_EN");
        regRead(AStagger, 32'd2, "STAGGER");
        checkOutput("boot addr", core_boot_addr_o, 32'h8000_1000);
        t = cyc + 1;
        regWrite(ACtrl, 32'h5);
        regWrite(AMask, 32'hF);
        regRead(AMask, 32'hB, "MASK write while busy");
        pulseDone(4'b1100);
        regRead(APending, 32'hB, "PENDING after early pulses");
        regRead(AStatus, 32'h1, "STATUS busy");
        regRead(AUnmap, 32'd0, "unmapped read");
        waitUntil(t + 12);
        checkOutput("core0 release cycle", 32'(relCyc[0]), 32'(t + 1));
        checkOutput("core1 release cycle", 32'(relCyc[1]), 32'(t + 4));
        checkOutput("core2 never released", 32'(relCyc[2]), 32'hFFFF_FFFF);
        checkOutput("core3 release cycle", 32'(relCyc[3]), 32'(t + 8));
        checkOutput("released cores", 32'(core_rst_no), 32'hB);
        checkOutput("fetch enables", 32'(core_fetch_en_o), 32'hB);
        pulseDone(4'b1000);
        @(negedge clk_i);
        pulseDone(4'b0001);
        regRead(APending, 32'h2, "PENDING before last");
        p = cyc;
        pulseDone(4'b0010);
        regWrite(AStatus, 32'h2);
        checkOutput("finish cores in reset", 32'(core_rst_no), 32'd0);
        checkOutput("finish fetch off", 32'(core_fetch_en_o), 32'd0);
        checkOutput("finish irq", 32'(irq_done_o), 32'd1);
        regRead(AStatus, 32'h2, "DONE kept over W1C");
        regRead(ACycles, 32'(p + 2 - t), "run CYCLES");

        $display("[TB] abort during run");
        regWrite(AStatus, 32'h2);
        t = cyc + 1;
        regWrite(ACtrl, 32'h5);
        waitUntil(t + 12);
        pulseDone(4'b1000);
        pulseDone(4'b0001);
        regRead(APending, 32'h2, "PENDING before abort");
        regWrite(ACtrl, 32'h6);
        checkOutput("abort cores in reset", 32'(core_rst_no), 32'd0);
        checkOutput("abort irq", 32'(irq_done_o), 32'd1);
        regRead(AStatus, 32'h4, "STATUS after abort");
        regWrite(AStatus, 32'h4);
        checkOutput("irq after ABORTED W1C", 32'(irq_done_o), 32'd0);
        regWrite(ACtrl, 32'h6);
        regRead(AStatus, 32'd0, "abort in idle");

        $display("[TB] abort together with final done pulse");
        regWrite(AMask, 32'h1);
        regWrite(AStagger, 32'd0);
        t = cyc + 1;
        regWrite(ACtrl, 32'h1);
        waitUntil(t + 6);
        core_done_i = 4'b0001;
        regWrite(ACtrl, 32'h2);
        core_done_i = '0;
        regRead(AStatus, 32'h4, "abort beats last done");
        checkOutput("irq gated off", 32'(irq_done_o), 32'd0);
        regWrite(AStatus, 32'h6);

        $display("[TB] reset mid-run");
        regWrite(AUnmap, 32'hFFFF_FFFF);
        regWrite(ACtrl, 32'h1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        regRead(AStatus, 32'd0, "STATUS after mid-run reset");
        regRead(AMask, 32'd0, "MASK after mid-run reset");
        checkOutput("cores after mid-run reset", 32'(core_rst_no), 32'd0);

        repeat (3) @(negedge clk_i);
        checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
